ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 8, address width; matches the 256-entry memory.
- DATA_W, 8, data width.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 command valid.
- m0_we  in  1  requester 0: 1=write, 0=read.
- m0_addr  in  ADDR_W  requester 0 address.
- m0_wdata  in  DATA_W  requester 0 write data.
- m0_gnt  out  1  one-cycle pulse: requester 0 command accepted.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  out  DATA_W  requester 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_wr  out  1  memory write enable; memory read occurs when low.
- ram_rdata  in  DATA_W  memory registered read data (1-cycle latency).

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, RESP.
REQ-004 In IDLE with any req high, the block SHALL pick a winner, latch its id/we/addr/wdata at the edge, and enter ISSUE.
REQ-005 Arbitration SHALL be round-robin: single requester wins; if both request, the one not granted last wins; last-grant pointer resets to 1, so m0 wins first.
REQ-006 In ISSUE, the winner's gnt SHALL be high for exactly that cycle; ram_addr/ram_wdata SHALL drive latched values; ram_wr SHALL equal latched we.
REQ-007 From ISSUE, a write SHALL return to IDLE; a read SHALL enter RESP.
REQ-008 In RESP, ram_rdata SHALL be captured into the winner's rdata register; that winner's rvalid SHALL be high the following cycle only.
REQ-009 Latency from the edge sampling req in IDLE:
- gnt: cycle +1.
- write committed: edge +2 (2-cycle occupancy).
- rvalid: cycle +3 (3-cycle occupancy).
REQ-010 ram_wr SHALL be 0 in every state except ISSUE-with-write.
REQ-011 ram_addr/ram_wdata SHALL hold their last value outside ISSUE.
REQ-012 Requester contract: hold req/we/addr/wdata stable until gnt; deassert req at the edge ending the gnt cycle unless issuing a new command.
REQ-013 Requests SHALL be sampled only in IDLE; req changes in ISSUE/RESP are ignored.
REQ-014 mX_rdata SHALL hold its value until the next read completes for that requester; the other requester's rdata SHALL be unchanged.
REQ-015 Simultaneous rvalid pulse for one requester and gnt to the other SHALL be permitted.

Reset
REQ-016 Reset SHALL force, asynchronously:
- state IDLE; last-grant pointer 1.
- all gnt, rvalid, ram_wr 0.
- ram_addr, ram_wdata, m0_rdata, m1_rdata 0.
REQ-017 Reset mid-operation SHALL abandon the command: no gnt/rvalid afterwards; a write already committed at an earlier edge remains in memory.

Structure
REQ-018 State encoding and ADDR_W/DATA_W defaults SHALL live in shared include ram_arb_defs.vh.
REQ-019 The two-way round-robin picker SHALL be sub-module rr_arb2: inputs req[1:0] and last-grant pointer; output one-hot grant.
REQ-020 The memory SHALL be instantiated outside this block and connected via ram_* ports.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- m0 write addr 0x10 data 0xA5, then m0 read 0x10 -> m0_gnt at cycles +1 and +3; m0_rvalid with m0_rdata=0xA5 at cycle +5.
- m0 and m1 both read continuously -> grants alternate m0,m1,m0,m1; each rvalid goes only to its owner.
- m1 writes 0x3C to 0xFF, m0 reads 0xFF back-to-back -> m0_rdata=0x3C; addr 0xFF with no wrap error.
- Reset asserted during RESP of an m1 read -> no m1_rvalid; outputs 0; next request is granted to m0 first.
- m0_req high with addr changing during ISSUE -> ram_addr keeps the latched value; ram_wr=0 throughout IDLE/RESP.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the two-requester RAM arbiter: default bus widths,
// the FSM state encoding, and the reset value of the last-grant pointer.
// Ports: none (package only).
package ram_arbiter_pkg;

  // Default widths; an 8-bit address matches the 256-entry memory.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // The last-grant pointer comes out of reset pointing at requester 1, so
  // requester 0 wins the first contested arbitration.
  localparam logic LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin picker. This block is purely combinational. A lone
// requester always wins. When both request, the one that was not granted
// last wins.
// Ports:
//   req[1:0]  in   request vector (bit i = requester i)
//   last_gnt  in   id of the requester granted most recently
//   grant     out  one-hot grant (all zero when nothing is requested)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM with registered reads between two requesters.
// In IDLE the block samples the requests and latches the winner's command.
// ISSUE then drives the command to the RAM and pulses the winner's gnt.
// Reads pass through RESP, where the RAM data is captured for the winner,
// and rvalid pulses on the cycle that follows.
// Ports:
//   clk, reset                        clock and async active-high reset
//   mX_req/we/addr/wdata              requester X command (X = 0, 1)
//   mX_gnt                            one-cycle command-accepted pulse
//   mX_rvalid/rdata                   one-cycle read-data-valid pulse and data
//   ram_addr/ram_wdata/ram_wr         memory command outputs
//   ram_rdata                         memory read data, one cycle after addr
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0] state;
  logic       last_gnt;
  logic       win_id;
  logic       win_we;
  logic [1:0] grant;

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .grant    (grant)
  );

  // Requests are looked at only in IDLE. ram_addr and ram_wdata are loaded
  // only when a command is accepted, so they also act as the latched command
  // and keep their value through RESP and the following IDLE cycles.
  // The rvalid pulses default low, so each one lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      last_gnt  <= LAST_GNT_RST;
      win_id    <= 1'b0;
      win_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            state    <= ST_ISSUE;
            win_id   <= grant[1];
            last_gnt <= grant[1];
            if (grant[1]) begin
              win_we    <= m1_we;
              ram_addr  <= m1_addr;
              ram_wdata <= m1_wdata;
            end else begin
              win_we    <= m0_we;
              ram_addr  <= m0_addr;
              ram_wdata <= m0_wdata;
            end
          end
        end
        ST_ISSUE: begin
          // The RAM commits a write at the end of this cycle. A read still
          // needs one more cycle for the registered RAM data.
          state <= win_we ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (win_id) begin
            m1_rdata  <= ram_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= ram_rdata;
            m0_rvalid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant and write enable are decoded from the state. Reset therefore
  // clears them immediately, along with the state register.
  always_comb begin
    m0_gnt = (state == ST_ISSUE) && !win_id;
    m1_gnt = (state == ST_ISSUE) &&  win_id;
    ram_wr = (state == ST_ISSUE) &&  win_we;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. It also models the external 256-entry
// RAM, which has registered reads. Expected results come from a
// transaction-level model: a round-robin winner choice, a shadow memory
// image, and the last read data for each requester.
module tb_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_wr;

  logic       q_req   [2];
  logic       q_we    [2];
  logic [7:0] q_addr  [2];
  logic [7:0] q_wdata [2];

  logic [7:0] mem     [0:255];
  logic [7:0] exp_mem [0:255];
  logic [7:0] exp_rdata [2];
  int         last_id;
  int         errors;
  int         checks;

  assign m0_req   = q_req[0];
  assign m0_we    = q_we[0];
  assign m0_addr  = q_addr[0];
  assign m0_wdata = q_wdata[0];
  assign m1_req   = q_req[1];
  assign m1_we    = q_we[1];
  assign m1_addr  = q_addr[1];
  assign m1_wdata = q_wdata[1];

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wr    (ram_wr),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: writes are synchronous, and read data appears one cycle
  // after the address.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Round-robin rule: a lone requester wins; with two, the one not granted last.
  function automatic int pick_winner();
    if (q_req[0] && q_req[1]) return (last_id == 0) ? 1 : 0;
    if (q_req[0]) return 0;
    return 1;
  endfunction

  function automatic logic [1:0] onehot(input int id);
    return (id == 0) ? 2'b01 : 2'b10;
  endfunction

  // One arbitration round, started while the DUT is in IDLE with the requests
  // already driven. With scramble set, the winner keeps req high and changes
  // its address and data after the grant (reads only).
  task automatic arbitrate(input bit scramble);
    int         w;
    logic [7:0] a, d;
    logic       we_l;
    if (!q_req[0] && !q_req[1]) begin
      @(posedge clk); #1;
      checks++;
      if ({m1_gnt, m0_gnt, ram_wr} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL idle_quiet: gnt/wr=%b required 000", {m1_gnt, m0_gnt, ram_wr});
      end
      return;
    end
    w = pick_winner();
    a = q_addr[w]; d = q_wdata[w]; we_l = q_we[w];
    @(posedge clk); #1;
    checks++;
    if ({m1_gnt, m0_gnt} !== onehot(w)) begin
      errors++;
      $display("[TB] FAIL grant: gnt=%b required %b", {m1_gnt, m0_gnt}, onehot(w));
    end
    checks++;
    if ({ram_addr, ram_wdata, ram_wr} !== {a, d, we_l}) begin
      errors++;
      $display("[TB] FAIL issue_cmd: addr/wdata/wr=%h/%h/%b required %h/%h/%b",
               ram_addr, ram_wdata, ram_wr, a, d, we_l);
    end
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rvalid_issue: rvalid=%b required 00", {m1_rvalid, m0_rvalid});
    end
    last_id = w;
    if (scramble) begin
      q_addr[w]  = 8'($urandom);
      q_wdata[w] = 8'($urandom);
    end else begin
      q_req[w] = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if ({m1_gnt, m0_gnt, ram_wr, ram_addr} !== {3'b000, a}) begin
      errors++;
      $display("[TB] FAIL after_issue: gnt/wr=%b addr=%h required 000 %h",
               {m1_gnt, m0_gnt, ram_wr}, ram_addr, a);
    end
    if (we_l) begin
      exp_mem[a] = d;
    end else begin
      checks++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rvalid_resp: rvalid=%b required 00", {m1_rvalid, m0_rvalid});
      end
      if (scramble) begin
        q_addr[w] = 8'($urandom);
        q_req[w]  = 1'b0;
      end
      @(posedge clk); #1;
      exp_rdata[w] = exp_mem[a];
      checks++;
      if ({m1_rvalid, m0_rvalid} !== onehot(w)) begin
        errors++;
        $display("[TB] FAIL rvalid: rvalid=%b required %b", {m1_rvalid, m0_rvalid}, onehot(w));
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        errors++;
        $display("[TB] FAIL rdata: m0/m1=%h/%h required %h/%h",
                 m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end
      checks++;
      if ({ram_wr, ram_addr} !== {1'b0, a}) begin
        errors++;
        $display("[TB] FAIL resp_hold: wr=%b addr=%h required 0 %h", ram_wr, ram_addr, a);
      end
    end
  endtask

  task automatic set_cmd(input int id, input logic we, input logic [7:0] a, input logic [7:0] d);
    q_req[id] = 1'b1; q_we[id] = we; q_addr[id] = a; q_wdata[id] = d;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr, ram_addr, ram_wdata, m0_rdata, m1_rdata}
        !== 37'd0) begin
      errors++;
      $display("[TB] FAIL %s: gnt=%b rvalid=%b wr=%b addr=%h wdata=%h rdata=%h/%h required all 0",
               name, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, ram_wr, ram_addr, ram_wdata,
               m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    set_cmd(0, 1'b1, 8'h10, 8'hA5);
    arbitrate(1'b0);
    set_cmd(0, 1'b0, 8'h10, 8'h00);
    arbitrate(1'b0);
    checks++;
    if (m0_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL write_read_data: m0_rdata=%h required a5", m0_rdata);
    end
  endtask

  task automatic test_alternate();
    int prev;
    prev = last_id;
    for (int i = 0; i < 6; i++) begin
      if (!q_req[0]) set_cmd(0, 1'b0, 8'h10 + 8'(i), 8'h00);
      if (!q_req[1]) set_cmd(1, 1'b0, 8'hF0 + 8'(i), 8'h00);
      arbitrate(1'b0);
      checks++;
      if (last_id == prev) begin
        errors++;
        $display("[TB] FAIL alternate: winner=%0d repeated", last_id);
      end
      prev = last_id;
    end
    q_req[0] = 1'b0;
    q_req[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_cmd(1, 1'b1, 8'hFF, 8'h3C);
    arbitrate(1'b0);
    set_cmd(0, 1'b0, 8'hFF, 8'h00);
    arbitrate(1'b0);
    checks++;
    if (m0_rdata !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL addr_ff_read: m0_rdata=%h required 3c", m0_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!q_req[r] && ($urandom_range(0, 9) < 7)) begin
          set_cmd(r, 1'($urandom), 8'hF8 + 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
      arbitrate(1'b0);
    end
    q_req[0] = 1'b0;
    q_req[1] = 1'b0;
  endtask

  task automatic test_addr_change();
    set_cmd(0, 1'b0, 8'h10, 8'h00);
    arbitrate(1'b1);
  endtask

  task automatic test_reset_mid_read();
    set_cmd(1, 1'b0, 8'hFF, 8'h00);
    @(posedge clk); #1;
    q_req[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    reset = 1'b0;
    last_id = 1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL post_reset_quiet: rvalid/gnt=%b required 0000",
                 {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt});
      end
    end
    set_cmd(0, 1'b0, 8'h10, 8'h00);
    set_cmd(1, 1'b0, 8'hFF, 8'h00);
    arbitrate(1'b0);
    checks++;
    if (last_id != 0) begin
      errors++;
      $display("[TB] FAIL first_after_reset: winner=%0d required 0", last_id);
    end
    arbitrate(1'b0);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    last_id = 1;
    reset   = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      q_req[r] = 1'b0; q_we[r] = 1'b0; q_addr[r] = 8'h00; q_wdata[r] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_addr_change();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
